// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start bit, LSB-first data, optional parity, stop period, all timed by s_tick.
// Define UART_TX_PARITY_EN to add the parity bit (odd/even selected by parity_odd).
module uart_tx_ctrl #(
  parameter int DataBits        = 8,
  parameter int OversampleTicks = 16,
  parameter int StopTicks       = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                s_tick,
  input  logic [DataBits-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  input  logic                parity_odd,
  output logic                tx,
  output logic                tx_busy,
  output logic                tx_done_tick
);

  localparam int MaxTicks = (OversampleTicks > StopTicks) ? OversampleTicks : StopTicks;
  localparam int TickW    = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;
  localparam int BitW     = (DataBits > 1) ? $clog2(DataBits) : 1;

  localparam logic [TickW-1:0] BitLast  = TickW'(OversampleTicks - 1);
  localparam logic [TickW-1:0] StopLast = TickW'(StopTicks - 1);
  localparam logic [BitW-1:0]  DataLast = BitW'(DataBits - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [TickW-1:0]    tick_q, tick_d;
  logic [BitW-1:0]     bit_q, bit_d;
  logic [DataBits-1:0] shreg_q, shreg_d;
  logic                tx_q, tx_d;
  logic                done_q, done_d;
  logic                period_end;

`ifdef UART_TX_PARITY_EN
  logic parity_q, parity_d;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  // The stop period has its own length; every other bit uses the oversample count.
  assign period_end = s_tick && (tick_q == ((state_q == STOP) ? StopLast : BitLast));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    tx_d     = tx_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    if (state_q != IDLE && s_tick) begin
      tick_d = period_end ? '0 : tick_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          shreg_d  = tx_data;
          tick_d   = '0;
          bit_d    = '0;
          tx_d     = 1'b0;
          state_d  = START;
`ifdef UART_TX_PARITY_EN
          parity_d = (^tx_data) ^ parity_odd;
`endif
        end
      end
      START: begin
        if (period_end) begin
          tx_d    = shreg_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (period_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == DataLast) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shreg_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (period_end) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (period_end) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  assign tx_ready     = (state_q == IDLE);
  assign tx_busy      = (state_q != IDLE);
  assign tx           = tx_q;
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: a tick-counting line model predicts tx, ready, busy and done every clock.
// Define UART_TX_PARITY_EN here as well as for the DUT to include the parity bit in the model.
module tb_uart_tx_ctrl;

  localparam int D  = 8;
  localparam int OT = 16;
  localparam int ST = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME_TICKS = OT * (1 + D + PB) + ST;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         s_tick = 1'b0;
  logic         tx_valid = 1'b0;
  logic         parity_odd = 1'b0;
  logic [D-1:0] tx_data = '0;
  logic         tx_ready, tx, tx_busy, tx_done_tick;

  int total = 0;
  int bad = 0;

  // clock / reset
  always #5 clk = ~clk;

  uart_tx_ctrl #(.DataBits(D), .OversampleTicks(OT), .StopTicks(ST)) dut (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .parity_odd(parity_odd),
    .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // tick source: 0 = stopped, 1 = every tick_div clocks, 2 = random 1-in-4
  int tick_mode = 0;
  int tick_div = 4;
  int tick_phase = 0;
  always @(posedge clk) begin
    #1;
    case (tick_mode)
      1: begin
        tick_phase = (tick_phase + 1) % tick_div;
        s_tick = (tick_phase == 0);
      end
      2: s_tick = ($urandom_range(0, 3) == 0);
      default: s_tick = 1'b0;
    endcase
  end

  // Expected line level after t ticks of a frame: start, LSB-first data, parity, stop.
  function automatic logic exp_bit(input logic [D-1:0] w, input logic p, input int t);
    int idx;
    idx = t / OT;
    if (idx == 0) return 1'b0;
    if (idx <= D) return w[idx-1];
    if (PB == 1 && idx == D + 1) return p;
    return 1'b1;
  endfunction

  // scoreboard / line model
  logic [D-1:0] exp_q[$];
  logic         par_q[$];
  logic [D-1:0] cur_word = '0;
  logic         cur_par = 1'b0;
  bit in_frame = 0;
  bit pend = 0;
  int t = 0;
  int started = 0, finished = 0, dut_done = 0;
  int clk_cnt = 0, fall_clk = 0, done_clk = 0, last_gap = 0;

  always @(negedge clk) begin
    clk_cnt++;
    if (!reset_n) begin
      in_frame = 0;
      pend = 0;
      t = 0;
      exp_q.delete();
      par_q.delete();
    end else begin
      if (tx_done_tick) dut_done++;
      if (pend) begin
        pend = 0;
        in_frame = 1;
        t = 0;
        cur_word = exp_q.pop_front();
        cur_par = par_q.pop_front();
        started++;
        last_gap = clk_cnt - done_clk;
        fall_clk = clk_cnt;
      end
      if (in_frame && t == FRAME_TICKS) begin
        check("done_pulse", tx_done_tick, 1);
        check("tx_end", tx, 1);
        check("ready_end", tx_ready, 1);
        check("busy_end", tx_busy, 0);
        in_frame = 0;
        finished++;
        done_clk = clk_cnt;
      end else if (in_frame) begin
        check("tx_bit", tx, exp_bit(cur_word, cur_par, t));
        check("ready_frame", tx_ready, 0);
        check("busy_frame", tx_busy, 1);
        check("done_frame", tx_done_tick, 0);
        t += int'(s_tick);
      end else begin
        check("tx_idle", tx, 1);
        check("ready_idle", tx_ready, 1);
        check("busy_idle", tx_busy, 0);
        check("done_idle", tx_done_tick, 0);
      end
      if (!in_frame && tx_valid) begin
        pend = 1;
        exp_q.push_back(tx_data);
        par_q.push_back((^tx_data) ^ parity_odd);
      end
    end
  end

  // driver tasks
  task automatic send(input logic [D-1:0] w);
    int s0, c;
    s0 = started;
    c = 0;
    @(posedge clk); #1;
    tx_data = w;
    tx_valid = 1'b1;
    while (started == s0 && c < 20000) begin
      @(negedge clk);
      c++;
    end
    check("accept_timeout", started > s0, 1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_finished(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (finished < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    check(tag, finished >= n, 1);
  endtask

  task automatic wait_bit(input int idx, input string tag);
    int c;
    c = 0;
    while (!(in_frame && t / OT == idx) && c < 20000) begin
      @(negedge clk);
      c++;
    end
    check(tag, in_frame && t / OT == idx, 1);
  endtask

  initial begin
    int f0, s0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done_tick, 0);
    reset_n = 1'b1;
    tick_mode = 1;
    repeat (5) @(posedge clk);

    // single 0xA5 frame, tick every 4 clk
    f0 = finished;
    send(8'hA5);
    wait_finished(f0 + 1, 5000, "a5_timeout");
    check("a5_latency", (done_clk - fall_clk) >= 637 && (done_clk - fall_clk) <= 640, 1);

    // back-to-back 0x00 then 0xFF with valid held
    f0 = finished;
    s0 = started;
    @(posedge clk); #1;
    tx_data = 8'h00;
    tx_valid = 1'b1;
    while (started < s0 + 1) @(negedge clk);
    @(posedge clk); #1;
    tx_data = 8'hFF;
    while (started < s0 + 2 && finished < f0 + 3) @(negedge clk);
    check("b2b_gap", last_gap, 1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    wait_finished(f0 + 2, 5000, "b2b_timeout");

    // mid-frame data change and valid pulse are ignored
    s0 = started;
    f0 = finished;
    send(8'h81);
    repeat (200) @(posedge clk);
    #1;
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    wait_finished(f0 + 1, 5000, "ign_timeout");
    repeat (20) @(posedge clk);
    check("ign_frames", started - s0, 1);

    // asynchronous reset during data bit 3
    send(8'h12);
    wait_bit(4, "bit3_reach");
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("abort_tx", tx, 1);
    check("abort_ready", tx_ready, 1);
    check("abort_busy", tx_busy, 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    f0 = finished;
    send(8'h55);
    wait_finished(f0 + 1, 5000, "x55_timeout");

    // s_tick stalled for 1000 clk mid data bit
    f0 = finished;
    send(8'hC3);
    wait_bit(3, "stall_reach");
    @(posedge clk); #1;
    tick_mode = 0;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    check("stall_tx", tx, exp_bit(cur_word, cur_par, t));
    tick_mode = 1;
    wait_finished(f0 + 1, 5000, "stall_timeout");

`ifdef UART_TX_PARITY_EN
    f0 = finished;
    parity_odd = 1'b0;
    send(8'h07);
    wait_finished(f0 + 1, 5000, "par_even_timeout");
    parity_odd = 1'b1;
    send(8'h07);
    wait_finished(f0 + 2, 5000, "par_odd_timeout");
`endif

    // randomized frames, random tick pattern and gaps
    tick_mode = 2;
    f0 = finished;
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 30)) @(posedge clk);
      parity_odd = 1'($urandom_range(0, 1));
      send(D'($urandom));
    end
    wait_finished(f0 + 12, 20000, "rand_timeout");
    repeat (10) @(posedge clk);

    check("done_count", dut_done, finished);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
UART transmit sequencer. Consumes the single-cycle oversample tick from the baud rate generator (16x baud by default) and serialises one parallel word per frame: start bit, data LSB-first, optional parity, stop bit(s). It sits between the host-side valid/ready write interface and the tx pin, and owns all bit timing derived from the shared baud tick.

Parameters:
DataBits, 8, data bits per frame; legal range 5..9.
OversampleTicks, 16, s_tick pulses per start/data/parity bit; must be >= 2.
StopTicks, 16, s_tick pulses for the stop period (16 = 1 bit, 24 = 1.5 bits, 32 = 2 bits); must be >= 1.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
s_tick  input  1  one-clk-wide oversample pulse from the baud rate generator
tx_data  input  DataBits  word to transmit
tx_valid  input  1  tx_data valid
tx_ready  output  1  controller can accept a word (high only in IDLE)
parity_odd  input  1  1 = odd parity, 0 = even; ignored unless UART_TX_PARITY_EN is defined
tx  output  1  serial line, idle high, registered
tx_busy  output  1  frame in progress (state != IDLE)
tx_done_tick  output  1  one-clk pulse when a frame completes

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, tx=1, tx_ready=1, tx_busy=0, tx_done_tick=0, all counters and shift register 0. Reset mid-frame aborts immediately; tx returns high with no partial stop bit.
- States: IDLE, START, DATA, PARITY (present only with macro), STOP.
- tx_ready = (state==IDLE); tx_busy = !tx_ready. Both are decoded from registered state.
- IDLE: on a clk edge with tx_valid=1, latch tx_data into the shift register, clear tick_cnt and bit_cnt, go to START, tx<=0. tx falls one clk after acceptance. tx_data and tx_valid are ignored while busy; no buffering.
- Counting: tick_cnt advances only on cycles with s_tick=1. A bit period ends on the s_tick where tick_cnt==limit-1; tick_cnt then clears. The first s_tick after acceptance counts as tick 0, so start-bit phase jitter is <= one s_tick interval.
- START: end of period -> DATA, tx<=shreg[0].
- DATA: end of period -> shift register right by 1, bit_cnt++. If bit_cnt==DataBits-1, go to PARITY (macro defined, tx<=parity bit) or STOP (tx<=1). Otherwise tx<=next bit.
- PARITY: end of period -> STOP, tx<=1.
- STOP: period limit is StopTicks. At the end -> IDLE, tx_done_tick<=1 for exactly one clk. tx_ready is high in that same cycle, so the next frame may be accepted then (back-to-back, no extra idle bit).
- s_tick never asserted: the FSM holds state and tx stays constant indefinitely.
- Widths: tick_cnt is $clog2(max(OversampleTicks,StopTicks)) bits; bit_cnt is $clog2(DataBits) bits, minimum 1. No wrap beyond limits.
- Frame length in ticks: OversampleTicks*(1+DataBits[+1]) + StopTicks.

Optional Feature:
UART_TX_PARITY_EN. When defined, the parity bit is computed at acceptance as (^tx_data) ^ parity_odd and sent in the PARITY state for OversampleTicks ticks. When undefined, the PARITY state and parity logic are absent, parity_odd is unused, and DATA goes directly to STOP.

Test Plan:
- Defaults, s_tick every 4 clk, send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each level held 64 clk; exactly one tx_done_tick 640 clk after tx falls; tx_ready low throughout the frame.
- Back-to-back 0x00 then 0xFF with tx_valid held high -> second start bit begins immediately after the first stop period; 2 done pulses; no idle-high gap beyond the 16-tick stop.
- Change tx_data to 0x3C and pulse tx_valid mid-frame while sending 0x81 -> 0x81 bits unaffected; the 0x3C pulse is not transmitted.
- Assert reset_n low during bit 3 of a frame -> tx=1, tx_ready=1, tx_busy=0 asynchronously; next frame 0x55 transmits correctly.
- Stop s_tick for 1000 clk in the middle of a data bit -> tx constant; frame resumes and completes with correct bit widths counted in ticks.
- With UART_TX_PARITY_EN, send 0x07 with parity_odd=0 -> parity bit 1; with parity_odd=1 -> 0. StopTicks=32 -> stop period 128 clk at the tick rate above.
